// File: rtl/aes_pkg.sv
// Shared AES-128 decryption types, GF(2^8) helpers and the inverse S-box.
// Byte k of a 128-bit block sits at bits[127-8k -: 8]. state[r][c] holds byte 4c+r.
package aes_pkg;

  localparam logic [3:0] NR = 4'd10;

  typedef logic [0:3][0:3][7:0] state_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FINAL} fsm_t;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Small-constant multiply; only 9, 11, 13 and 14 are used by InvMixColumns.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // Coefficient for input row k feeding output row r: row 0 is {e,b,d,9}, later rows rotate right.
  function automatic logic [3:0] inv_mix_coef(input logic [1:0] idx);
    case (idx)
      2'd0:    return 4'he;
      2'd1:    return 4'hb;
      2'd2:    return 4'hd;
      default: return 4'h9;
    endcase
  endfunction

  function automatic state_t to_state(input logic [127:0] b);
    state_t s;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = b[127-8*(4*c+r) -: 8];
    return s;
  endfunction

  function automatic logic [127:0] from_state(input state_t s);
    logic [127:0] b;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[127-8*(4*c+r) -: 8] = s[r][c];
    return b;
  endfunction

  function automatic state_t inv_shift_rows(input state_t s);
    state_t n;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        n[r][2'(c + r)] = s[r][c];
    return n;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse-cipher round, shared by the nine full rounds and the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  state_t       s,
  input  logic [127:0] rk,
  input  logic         final_rnd,
  output logic [127:0] s_out
);

  state_t shifted;
  state_t subbed;
  state_t added;
  state_t mixed;

  always_comb begin
    shifted = inv_shift_rows(s);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        subbed[r][c] = INV_SBOX[shifted[r][c]];
    added = to_state(from_state(subbed) ^ rk);
    mixed = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++)
          mixed[r][c] = mixed[r][c] ^ gf_mul(added[k][c], inv_mix_coef(2'(k - r)));
    s_out = final_rnd ? from_state(added) : from_state(mixed);
  end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryptor: one round per clock, round keys fetched by index in the same cycle.
// Start-to-done is 11 clocks; plaintext holds until the next completion.
module aes_inv_cipher
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] ciphertext,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         busy,
  output logic         done,
  output logic [127:0] plaintext
);

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] state_q, state_d;
  logic [127:0] pt_q, pt_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  state_t       cur_s;
  logic [127:0] rnd_out;

  assign cur_s = to_state(state_q);

  aes_inv_round u_round (
    .s         (cur_s),
    .rk        (rk),
    .final_rnd (fsm_q == ST_FINAL),
    .s_out     (rnd_out)
  );

  // Key index is decoded from registered state only, so the rk lookup never loops back.
  always_comb begin
    case (fsm_q)
      ST_ROUND: rk_idx = round_q;
      ST_FINAL: rk_idx = 4'd0;
      default:  rk_idx = NR;
    endcase
  end

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    pt_d    = pt_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ciphertext ^ rk;
          round_d = NR - 4'd1;
          fsm_d   = ST_ROUND;
          busy_d  = 1'b1;
        end
      end
      ST_ROUND: begin
        state_d = rnd_out;
        if (round_q == 4'd1) begin
          round_d = 4'd0;
          fsm_d   = ST_FINAL;
        end else begin
          round_d = round_q - 4'd1;
        end
      end
      ST_FINAL: begin
        pt_d   = rnd_out;
        done_d = 1'b1;
        busy_d = 1'b0;
        fsm_d  = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= ST_IDLE;
      round_q <= 4'd0;
      state_q <= '0;
      pt_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
      pt_q    <= pt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign plaintext = pt_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: forward AES reference (S-box derived from GF inverse) supplies
// round keys and ciphertexts; a transaction model predicts done/busy/rk_idx/plaintext each cycle.
module tb_aes_inv_cipher;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] ciphertext = '0;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         busy, done;
  logic [127:0] plaintext;

  logic [127:0] rkeys [0:15];
  logic [7:0]   sb [0:255];

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;

  int           m_cnt = 0;
  logic [127:0] m_pend = '0;
  logic [127:0] m_pt = '0;
  logic         m_done = 1'b0;
  logic [127:0] cur_pt = '0;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;

  always #5 clk = ~clk;

  assign rk = rkeys[rk_idx];

  aes_inv_cipher dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ciphertext (ciphertext),
    .rk_idx     (rk_idx),
    .rk         (rk),
    .busy       (busy),
    .done       (done),
    .plaintext  (plaintext)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] a;
    p = '0;
    a = a_in;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s, n;
    logic [7:0] a0, a1, a2, a3;
    s = pt ^ rkeys[0];
    for (int r = 1; r <= 10; r++) begin
      for (int k = 0; k < 16; k++) s[127-8*k -: 8] = sb[s[127-8*k -: 8]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          n[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
      s = n;
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8];
          a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8];
          a3 = s[103-32*c -: 8];
          n[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          n[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          n[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          n[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        s = n;
      end
      s = s ^ rkeys[r];
    end
    return s;
  endfunction

  // Transaction model: a block accepted while idle completes ten edges later.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt  <= 0;
      m_pt   <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          m_pend <= cur_pt;
          m_cnt  <= 1;
        end
      end else if (m_cnt == 10) begin
        m_pt   <= m_pend;
        m_done <= 1'b1;
        m_cnt  <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_done", 128'(done), 128'(m_done));
    chk("cyc_busy", 128'(busy), 128'(m_cnt != 0));
    chk("cyc_rk_idx", 128'(rk_idx), 128'((m_cnt == 0) ? 10 : 10 - m_cnt));
    chk("cyc_plaintext", plaintext, m_pt);
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input logic [127:0] ct, input logic [127:0] pt);
    ciphertext = ct;
    cur_pt = pt;
    start = 1'b1;
    tick();
    start = 1'b0;
    ciphertext = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Strict latency: ten further edges, done only after the last, prior result held until then.
  task automatic run_to_done(input logic [127:0] exp, input logic [127:0] prev, input string nm);
    for (int i = 1; i <= 10; i++) begin
      chk({nm, "_rkseq"}, 128'(rk_idx), 128'(10 - i));
      chk({nm, "_early_done"}, 128'(done), 128'(0));
      chk({nm, "_hold"}, plaintext, prev);
      tick();
    end
    chk({nm, "_done"}, 128'(done), 128'(1));
    chk({nm, "_busy_in_done"}, 128'(busy), 128'(0));
    chk({nm, "_pt"}, plaintext, exp);
  endtask

  task automatic wait_done(input logic [127:0] exp, input string nm);
    int n;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, 128'(done), 128'(1));
    chk({nm, "_pt"}, plaintext, exp);
  endtask

  initial begin
    logic [127:0] pa, pb, ca, cb, k, p, c;
    int d0;
    for (int i = 0; i < 16; i++) rkeys[i] = '0;
    build_sbox();

    // Reference pins: S-box entries, last round keys and FIPS-197 encryptions.
    chk("sbox_00", 128'(sb[8'h00]), 128'h63);
    chk("sbox_53", 128'(sb[8'h53]), 128'hed);
    set_key(KB);
    chk("keyB_rk10", rkeys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("encB", encrypt(PTB), CTB);
    set_key(K1);
    chk("key1_rk10", rkeys[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("enc1", encrypt(PT1), CT1);

    tick();
    tick();
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_rk_idx", 128'(rk_idx), 128'(10));
    chk("rst_pt", plaintext, 128'(0));
    reset = 1'b0;
    tick();

    // FIPS-197 C.1 with state probe and exact latency.
    chk("c1_idle_rk", 128'(rk_idx), 128'(10));
    start_block(CT1, PT1);
    chk("c1_state_probe", dut.state_q, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
    run_to_done(PT1, 128'(0), "c1");

    // FIPS-197 B started in the done cycle of C.1.
    set_key(KB);
    chk("b_idle_rk", 128'(rk_idx), 128'(10));
    start_block(CTB, PTB);
    run_to_done(PTB, PT1, "b2b");

    // start pulsed while busy at edge 5 with a different ciphertext is ignored.
    set_key(K1);
    tick();
    pa = {$urandom, $urandom, $urandom, $urandom};
    pb = {$urandom, $urandom, $urandom, $urandom};
    ca = encrypt(pa);
    cb = encrypt(pb);
    d0 = done_cnt;
    start_block(ca, pa);
    repeat (4) tick();
    ciphertext = cb;
    cur_pt = pb;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("ign_done", 128'(done), 128'(1));
    chk("ign_pt", plaintext, pa);
    repeat (3) tick();
    chk("ign_one_done", 128'(done_cnt - d0), 128'(1));

    // Reset at edge 6 aborts; a fresh start right after release decrypts C.1.
    start_block(CT1, PT1);
    repeat (6) tick();
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    chk("abort_pt", plaintext, 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_done", 128'(done), 128'(0));
    chk("abort_rk_idx", 128'(rk_idx), 128'(10));
    tick();
    tick();
    reset = 1'b0;
    chk("abort_no_done", 128'(done_cnt - d0), 128'(0));
    start_block(CT1, PT1);
    run_to_done(PT1, 128'(0), "post_rst");

    // Round trip against the reference encryptor.
    for (int i = 0; i < 1000; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      set_key(k);
      c = encrypt(p);
      start_block(c, p);
      wait_done(p, "roundtrip");
    end

    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
